// File: rtl/lsu_store_buffer_if.sv
// Request/response and data-memory port bundle for lsu_store_buffer.
// The slave modport is the store buffer; master is the pipeline/memory side.
interface lsu_store_buffer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        buf_empty;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, buf_empty,
           mem_access_addr, mem_write_data, mem_write_en, mem_read
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, buf_empty,
           mem_access_addr, mem_write_data, mem_write_en, mem_read
  );
endinterface

// File: rtl/lsu_store_buffer.sv
// Load/store front end owning the single data-memory port.
// Stores are posted into an in-order FIFO and drained when no load needs the
// port; loads get a registered one-cycle response.
// Optional feature macro: LSU_FWD_EN -- forward data from buffered stores to
// hitting loads. When undefined, a hitting load is stalled until the matching
// entries have drained and then reads memory.
module lsu_store_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_BITS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  lsu_store_buffer_if.slave  bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [15:0] addr_q [DEPTH];
  logic [15:0] data_q [DEPTH];
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_rdata_q, resp_rdata_d;

  logic        full;
  logic        hit;
  logic        req_ready;
  logic        load_acc;
  logic        store_acc;
  logic        drain;
`ifdef LSU_FWD_EN
  logic [15:0] fwd_data;
`endif

  // Hit search from oldest to youngest so the last match is the youngest one.
  always_comb begin
    hit = 1'b0;
`ifdef LSU_FWD_EN
    fwd_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) &&
          (addr_q[rd_ptr_q + PW'(i)][ADDR_BITS-1:0] == bus.req_addr[ADDR_BITS-1:0])) begin
        hit = 1'b1;
`ifdef LSU_FWD_EN
        fwd_data = data_q[rd_ptr_q + PW'(i)];
`endif
      end
    end
  end

  // Acceptance and port arbitration: load first, then drain, else idle.
  always_comb begin
    full = (count_q == cnt_t'(DEPTH));
`ifdef LSU_FWD_EN
    req_ready = !full;
`else
    req_ready = !full && !(bus.req_valid && !bus.req_we && hit);
`endif
    load_acc  = bus.req_valid && req_ready && !bus.req_we;
    store_acc = bus.req_valid && req_ready && bus.req_we;
    drain     = !load_acc && (count_q != '0);
  end

  // Memory port drive.
  always_comb begin
    bus.mem_read        = 1'b0;
    bus.mem_write_en    = 1'b0;
    bus.mem_access_addr = '0;
    bus.mem_write_data  = '0;
    if (load_acc) begin
      bus.mem_read        = 1'b1;
      bus.mem_access_addr = bus.req_addr;
    end else if (drain) begin
      bus.mem_write_en    = 1'b1;
      bus.mem_access_addr = addr_q[rd_ptr_q];
      bus.mem_write_data  = data_q[rd_ptr_q];
    end
  end

  // Pointer/count and load response next-state.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + ptr_t'(store_acc);
    rd_ptr_d     = rd_ptr_q + ptr_t'(drain);
    count_d      = count_q + cnt_t'(store_acc) - cnt_t'(drain);
    resp_valid_d = load_acc;
    resp_rdata_d = resp_rdata_q;
    if (load_acc) begin
`ifdef LSU_FWD_EN
      resp_rdata_d = hit ? fwd_data : bus.mem_read_data;
`else
      resp_rdata_d = bus.mem_read_data;
`endif
    end
  end

  // Control state with asynchronous reset; buffered stores are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      addr_q[wr_ptr_q] <= bus.req_addr;
      data_q[wr_ptr_q] <= bus.req_wdata;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.buf_empty  = (count_q == '0);
endmodule

// File: tb/tb_lsu_store_buffer.sv
// Self-checking bench for lsu_store_buffer: a queue-based reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized traffic with occasional asynchronous resets.
module tb_lsu_store_buffer;
  localparam int unsigned DEPTH = 4;
`ifdef LSU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_mem = 1'b1;

  int total = 0;
  int bad = 0;

  lsu_store_buffer_if b();

  lsu_store_buffer #(.DEPTH(DEPTH), .ADDR_BITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  always #5 clk = ~clk;

  // Data memory environment: 8 words decoded by addr[2:0].
  logic [15:0] mem [8];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 8; k++) mem[k] <= 16'hC000 | 16'(k);
    end else if (b.mem_write_en) begin
      mem[b.mem_access_addr[2:0]] <= b.mem_write_data;
    end
  end
  assign b.mem_read_data = b.mem_read ? mem[b.mem_access_addr[2:0]] : 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of buffered stores plus a model memory.
  ent_t        sb_q[$];
  logic [15:0] ref_mem [8];
  bit          exp_rv;
  logic [15:0] exp_rd;
  bit          m_hit, m_ready, m_load, m_store, m_drain;
  logic [15:0] m_fwd;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_rv = 1'b0;
      exp_rd = '0;
      if (init_mem) for (int k = 0; k < 8; k++) ref_mem[k] = 16'hC000 | 16'(k);
    end else begin
      m_hit = 1'b0;
      m_fwd = '0;
      foreach (sb_q[k]) begin
        if (sb_q[k].a[2:0] == b.req_addr[2:0]) begin
          m_hit = 1'b1;
          m_fwd = sb_q[k].d;
        end
      end
      m_ready = (sb_q.size() < int'(DEPTH)) && (FWD || !(b.req_valid && !b.req_we && m_hit));
      m_load  = b.req_valid && m_ready && !b.req_we;
      m_store = b.req_valid && m_ready && b.req_we;
      m_drain = !m_load && (sb_q.size() != 0);
      chk("req_ready", 32'(b.req_ready), 32'(m_ready));
      chk("buf_empty", 32'(b.buf_empty), 32'(sb_q.size() == 0));
      chk("mem_read", 32'(b.mem_read), 32'(m_load));
      chk("mem_write_en", 32'(b.mem_write_en), 32'(m_drain));
      chk("mem_access_addr", 32'(b.mem_access_addr),
          32'(m_load ? b.req_addr : (m_drain ? sb_q[0].a : 16'h0000)));
      chk("mem_write_data", 32'(b.mem_write_data), 32'(m_drain ? sb_q[0].d : 16'h0000));
      chk("resp_valid", 32'(b.resp_valid), 32'(exp_rv));
      if (exp_rv) chk("resp_rdata", 32'(b.resp_rdata), 32'(exp_rd));
      exp_rv = m_load;
      if (m_load) exp_rd = m_hit ? m_fwd : ref_mem[b.req_addr[2:0]];
      if (m_drain) begin
        ref_mem[sb_q[0].a[2:0]] = sb_q[0].d;
        void'(sb_q.pop_front());
      end
      if (m_store) sb_q.push_back('{a: b.req_addr, d: b.req_wdata});
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer (and, for a
  // load, after the response cycle).
  task automatic do_req(input bit we, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output bit first_ready);
    bit acc = 1'b0;
    rd = '0;
    first_ready = 1'b0;
    b.req_valid = 1'b1;
    b.req_we    = we;
    b.req_addr  = a;
    b.req_wdata = d;
    for (int n = 0; n < 20; n++) begin
      #3;
      if (n == 0) first_ready = b.req_ready;
      if (b.req_ready) acc = 1'b1;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    b.req_valid = 1'b0;
    if (!acc) chk("req_timeout", 32'd0, 32'd1);
    if (acc && !we) begin
      #3;
      chk("load_resp_valid", 32'(b.resp_valid), 32'd1);
      rd = b.resp_rdata;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] rd;
  bit          fr;

  initial begin
    b.req_valid = 1'b0;
    b.req_we    = 1'b0;
    b.req_addr  = '0;
    b.req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    init_mem = 1'b0;
    #3;
    chk("rst_buf_empty", 32'(b.buf_empty), 32'd1);
    chk("rst_req_ready", 32'(b.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(b.resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(b.resp_rdata), 32'd0);
    chk("rst_mem_idle", {b.mem_access_addr, b.mem_write_data} | 32'({b.mem_write_en, b.mem_read}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Store then drain in the next cycle.
    do_req(1'b1, 16'd2, 16'hA5A5, rd, fr);
    #3;
    chk("drain_we", 32'(b.mem_write_en), 32'd1);
    chk("drain_addr", 32'(b.mem_access_addr), 32'd2);
    chk("drain_data", 32'(b.mem_write_data), 32'h0000A5A5);
    @(posedge clk);
    #4;
    chk("drain_empty", 32'(b.buf_empty), 32'd1);
    @(posedge clk);
    #1;

    // Two stores to the same address, then a load of it.
    do_req(1'b1, 16'd3, 16'h1111, rd, fr);
    do_req(1'b1, 16'd3, 16'h2222, rd, fr);
    do_req(1'b0, 16'd3, 16'h0000, rd, fr);
    chk("fwd_ready", 32'(fr), 32'(FWD));
    chk("fwd_rdata", 32'(rd), 32'h00002222);

    // Aliasing on the low address bits.
    do_req(1'b1, 16'h000B, 16'h00FF, rd, fr);
    do_req(1'b0, 16'h0003, 16'h0000, rd, fr);
    chk("alias_ready", 32'(fr), 32'(FWD));
    chk("alias_rdata", 32'(rd), 32'h000000FF);

    // Ordering miss: buffered store to 1, load of 5 reads memory first.
    do_req(1'b1, 16'd1, 16'h1357, rd, fr);
    b.req_valid = 1'b1;
    b.req_we    = 1'b0;
    b.req_addr  = 16'd5;
    #3;
    chk("miss_ready", 32'(b.req_ready), 32'd1);
    chk("miss_mem_read", 32'(b.mem_read), 32'd1);
    chk("miss_no_write", 32'(b.mem_write_en), 32'd0);
    @(posedge clk);
    #1;
    b.req_valid = 1'b0;
    #3;
    chk("miss_resp_valid", 32'(b.resp_valid), 32'd1);
    chk("miss_rdata", 32'(b.resp_rdata), 32'h0000C005);
    chk("miss_drain_we", 32'(b.mem_write_en), 32'd1);
    chk("miss_drain_addr", 32'(b.mem_access_addr), 32'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset while a store is about to drain.
    do_req(1'b1, 16'd6, 16'hBEEF, rd, fr);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_buf_empty", 32'(b.buf_empty), 32'd1);
    chk("arst_resp_valid", 32'(b.resp_valid), 32'd0);
    chk("arst_write_en", 32'(b.mem_write_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_mem6", 32'(mem[6]), 32'h0000C006);

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        b.req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        b.req_valid = ($urandom_range(0, 3) != 0);
        b.req_we    = $urandom_range(0, 1) == 1;
        b.req_addr  = 16'($urandom);
        b.req_wdata = 16'($urandom);
        @(posedge clk);
        #1;
      end
    end
    b.req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) chk("final_mem", 32'(mem[k]), 32'(ref_mem[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
